instr_sequencer: RTL and testbench
==================================

# instr_sequencer

- Major-state control sequencer of the PDP-8 core.
- Sits directly downstream of the IR decoder: it consumes the opcode one-hots and the addressing-mode lines for the instruction held in IR.
- It steps each instruction through fetch, defer/auto-index and execute.
- It drives memory request strobes, the memory-address source select and one-cycle datapath strobes.

## Interface
- Parameters: none.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- RUN  in  1  1 = execute instructions; 0 = stop at next instruction boundary.
- MEM_DONE  in  1  one-cycle memory completion; ignored when no request is active.
- AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR  in  1 each  opcode one-hots from the decoder; valid from the cycle after IR_LD.
- IND, PPIND  in  1 each  indirect; auto-index indirect (page-zero 0010–0017). PPIND implies IND.
- SKIP  in  1  datapath result-is-zero after increment; sampled only in E_WR for ISZ.
- STATE  out  4  current state code.
- MEM_RD, MEM_WR  out  1 each  memory request; held high until MEM_DONE, inclusive.
- MA_SEL  out  2  address source: 0 = PC, 1 = IR effective address, 2 = MD (indirect pointer).
- IR_LD, PC_INC, PC_LD, MD_INC, AC_OP, INSTR_DONE  out  1 each  one-cycle strobes.
- PC_TO_MD, AC_TO_MD  out  1 each  write-data source select; level signals.

## Operation
**State codes**
- IDLE=0, F_RD=1, F_DEC=2, D_RD=3, D_INC=4, D_WB=5, E_RD=6, E_INC=7, E_WR=8, EXE_OP=9, J_LD=10, J_INC=11.

**State behaviour and transitions**
- IDLE: all outputs 0. Go to F_RD when RUN=1.
- F_RD: MA_SEL=0, MEM_RD=1. On MEM_DONE: IR_LD=1 and PC_INC=1 in the same cycle, then go to F_DEC.
- F_DEC: decode settle cycle; no strobes. Dispatch:
  - OPR, IOT, or no opcode line asserted → EXE_OP.
  - IND → D_RD.
  - JMP → J_LD.
  - JMS, DCA → E_WR.
  - AAND, TAD, ISZ → E_RD.
- D_RD: MA_SEL=1, MEM_RD=1. On MEM_DONE: go to D_INC if PPIND, else to the execute dispatch (same rule as F_DEC minus the IND branch). Sets internal flag EA_IND.
- D_INC: MD_INC=1 for one cycle, then D_WB.
- D_WB: MA_SEL=1, MEM_WR=1. On MEM_DONE, go to the execute dispatch.
- Execute states: MA_SEL = 2 if EA_IND, else 1.
- E_RD: MEM_RD=1. On MEM_DONE:
  - AAND/TAD: AC_OP=1 and INSTR_DONE=1.
  - ISZ: go to E_INC.
- E_INC: MD_INC=1, then E_WR.
- E_WR: MEM_WR=1. AC_TO_MD=1 for DCA; PC_TO_MD=1 for JMS. On MEM_DONE:
  - DCA: AC_OP=1 (AC clear) and INSTR_DONE=1.
  - ISZ: PC_INC=SKIP and INSTR_DONE=1.
  - JMS: go to J_LD.
- J_LD: PC_LD=1 (PC ← effective address).
  - JMP: INSTR_DONE=1.
  - JMS: go to J_INC.
- J_INC: PC_INC=1, INSTR_DONE=1.
- EXE_OP: AC_OP=1 if OPR or IOT asserted; INSTR_DONE=1.

**Instruction completion**
- After the INSTR_DONE cycle: next state F_RD if RUN=1, else IDLE.
- EA_IND clears on every entry to F_RD.

## Timing
- Outputs are decoded from STATE. IR_LD, PC_INC, AC_OP and INSTR_DONE that are gated by MEM_DONE are Mealy (same cycle as MEM_DONE).
- Reset: RESET_N sampled low → STATE=IDLE at that edge. All outputs 0 while RESET_N is low and in the first IDLE cycle. EA_IND=0.
- Reset mid-operation: abandons any memory request. A MEM_DONE coincident with RESET_N low is ignored.
- RUN falling mid-instruction: the current instruction completes; stop occurs only at the boundary.
- Wait states: extra cycles before MEM_DONE hold the state and all level outputs unchanged. Strobes never repeat during wait states.
- Latency, fetch entry to next fetch entry, with MEM_DONE in the first request cycle:
  - OPR/IOT, JMP, AAND/TAD direct, DCA: 3 cycles.
  - TAD indirect: 4 cycles.
  - TAD auto-index: 6 cycles.
  - ISZ direct: 5 cycles.
  - JMS direct: 5 cycles.
- Each wait cycle adds 1.
- Exactly one INSTR_DONE pulse per instruction.

## Test plan
- Reset: RESET_N=0 for 2 cycles with RUN=1 and MEM_DONE=1 → STATE=0, all outputs 0. After release, STATE=1 one cycle later with MEM_RD=1 and MA_SEL=0.
- TAD direct, zero-wait memory → STATE sequence 1,2,6,1.
  - IR_LD and PC_INC in cycle 1.
  - AC_OP and INSTR_DONE in cycle 3.
- TAD auto-index (IND=PPIND=1), 2 wait cycles on every access:
  - Sequence 1,1,1,2,3,3,3,4,5,5,5,6,6,6.
  - MD_INC exactly once, in state 4.
  - MA_SEL=2 in state 6.
- ISZ: SKIP=1 → PC_INC in the final E_WR cycle. SKIP=0 → no PC_INC. 5 cycles either way.
- JMS direct → MEM_WR with PC_TO_MD=1, then PC_LD, then PC_INC in consecutive cycles. INSTR_DONE only with PC_INC.
- RUN dropped during D_RD → instruction completes, INSTR_DONE pulses once, STATE=0 next. Asserting RESET_N=0 during an E_WR wait instead → IDLE, MEM_WR=0 immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// Major-state control sequencer for the PDP-8 core.
// Walks each instruction through fetch, optional defer/auto-index and
// execute, issuing memory requests, the memory-address source select and
// one-cycle datapath strobes. Outputs decode from the current state; the
// strobes tied to a memory completion are Mealy on MEM_DONE.
module instr_sequencer (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       MEM_DONE,
  input  logic       AAND,
  input  logic       TAD,
  input  logic       ISZ,
  input  logic       DCA,
  input  logic       JMS,
  input  logic       JMP,
  input  logic       IOT,
  input  logic       OPR,
  input  logic       IND,
  input  logic       PPIND,
  input  logic       SKIP,
  output logic [3:0] STATE,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic [1:0] MA_SEL,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       MD_INC,
  output logic       AC_OP,
  output logic       INSTR_DONE,
  output logic       PC_TO_MD,
  output logic       AC_TO_MD
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] F_RD   = 4'd1;
  localparam logic [3:0] F_DEC  = 4'd2;
  localparam logic [3:0] D_RD   = 4'd3;
  localparam logic [3:0] D_INC  = 4'd4;
  localparam logic [3:0] D_WB   = 4'd5;
  localparam logic [3:0] E_RD   = 4'd6;
  localparam logic [3:0] E_INC  = 4'd7;
  localparam logic [3:0] E_WR   = 4'd8;
  localparam logic [3:0] EXE_OP = 4'd9;
  localparam logic [3:0] J_LD   = 4'd10;
  localparam logic [3:0] J_INC  = 4'd11;

  localparam logic [1:0] MA_PC = 2'd0;
  localparam logic [1:0] MA_EA = 2'd1;
  localparam logic [1:0] MA_MD = 2'd2;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       ea_ind_r;
  logic       ea_ind_next_s;
  logic       ea_set_s;
  logic       no_op_s;
  logic [3:0] exec_target_s;
  logic [3:0] dec_target_s;
  logic [3:0] boundary_s;
  logic [1:0] ma_exec_s;

  logic       mem_rd_s;
  logic       mem_wr_s;
  logic [1:0] ma_sel_s;
  logic       ir_ld_s;
  logic       pc_inc_s;
  logic       pc_ld_s;
  logic       md_inc_s;
  logic       ac_op_s;
  logic       instr_done_s;
  logic       pc_to_md_s;
  logic       ac_to_md_s;

  assign no_op_s = ~(AAND | TAD | ISZ | DCA | JMS | JMP | IOT | OPR);

  // Dispatch targets: execute entry, decode entry (adds the defer branch), and the instruction boundary.
  always_comb begin
    if (OPR | IOT | no_op_s) begin
      exec_target_s = EXE_OP;
    end else if (JMP) begin
      exec_target_s = J_LD;
    end else if (JMS | DCA) begin
      exec_target_s = E_WR;
    end else begin
      exec_target_s = E_RD;
    end
    if (OPR | IOT | no_op_s) begin
      dec_target_s = EXE_OP;
    end else if (IND) begin
      dec_target_s = D_RD;
    end else begin
      dec_target_s = exec_target_s;
    end
    if (RUN) begin
      boundary_s = F_RD;
    end else begin
      boundary_s = IDLE;
    end
    if (ea_ind_r) begin
      ma_exec_s = MA_MD;
    end else begin
      ma_exec_s = MA_EA;
    end
  end

  // Next-state and raw output decode; wait states simply hold the state.
  always_comb begin
    next_state_s = state_r;
    ea_set_s     = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    ma_sel_s     = MA_PC;
    ir_ld_s      = 1'b0;
    pc_inc_s     = 1'b0;
    pc_ld_s      = 1'b0;
    md_inc_s     = 1'b0;
    ac_op_s      = 1'b0;
    instr_done_s = 1'b0;
    pc_to_md_s   = 1'b0;
    ac_to_md_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (RUN) begin
          next_state_s = F_RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      F_RD: begin
        mem_rd_s = 1'b1;
        if (MEM_DONE) begin
          ir_ld_s      = 1'b1;
          pc_inc_s     = 1'b1;
          next_state_s = F_DEC;
        end else begin
          next_state_s = F_RD;
        end
      end
      F_DEC: begin
        next_state_s = dec_target_s;
      end
      D_RD: begin
        mem_rd_s = 1'b1;
        ma_sel_s = MA_EA;
        if (MEM_DONE) begin
          ea_set_s = 1'b1;
          if (PPIND) begin
            next_state_s = D_INC;
          end else begin
            next_state_s = exec_target_s;
          end
        end else begin
          next_state_s = D_RD;
        end
      end
      D_INC: begin
        md_inc_s     = 1'b1;
        next_state_s = D_WB;
      end
      D_WB: begin
        mem_wr_s = 1'b1;
        ma_sel_s = MA_EA;
        if (MEM_DONE) begin
          next_state_s = exec_target_s;
        end else begin
          next_state_s = D_WB;
        end
      end
      E_RD: begin
        mem_rd_s = 1'b1;
        ma_sel_s = ma_exec_s;
        if (MEM_DONE) begin
          if (ISZ) begin
            next_state_s = E_INC;
          end else begin
            ac_op_s      = AAND | TAD;
            instr_done_s = 1'b1;
            next_state_s = boundary_s;
          end
        end else begin
          next_state_s = E_RD;
        end
      end
      E_INC: begin
        md_inc_s     = 1'b1;
        ma_sel_s     = ma_exec_s;
        next_state_s = E_WR;
      end
      E_WR: begin
        mem_wr_s   = 1'b1;
        ma_sel_s   = ma_exec_s;
        ac_to_md_s = DCA;
        pc_to_md_s = JMS;
        if (MEM_DONE) begin
          if (JMS) begin
            next_state_s = J_LD;
          end else begin
            ac_op_s      = DCA;
            pc_inc_s     = ISZ & SKIP;
            instr_done_s = 1'b1;
            next_state_s = boundary_s;
          end
        end else begin
          next_state_s = E_WR;
        end
      end
      J_LD: begin
        pc_ld_s  = 1'b1;
        ma_sel_s = ma_exec_s;
        if (JMS) begin
          next_state_s = J_INC;
        end else begin
          instr_done_s = 1'b1;
          next_state_s = boundary_s;
        end
      end
      J_INC: begin
        pc_inc_s     = 1'b1;
        ma_sel_s     = ma_exec_s;
        instr_done_s = 1'b1;
        next_state_s = boundary_s;
      end
      EXE_OP: begin
        ac_op_s      = OPR | IOT;
        ma_sel_s     = ma_exec_s;
        instr_done_s = 1'b1;
        next_state_s = boundary_s;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    // The indirect flag belongs to one instruction: drop it whenever a fetch begins.
    if (next_state_s == F_RD) begin
      ea_ind_next_s = 1'b0;
    end else begin
      ea_ind_next_s = ea_ind_r | ea_set_s;
    end
  end

  // State and indirect-flag registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r  <= IDLE;
      ea_ind_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      ea_ind_r <= ea_ind_next_s;
    end
  end

  // Force every output low while reset is asserted so a pending request is dropped at once.
  always_comb begin
    if (RESET_N) begin
      STATE      = state_r;
      MEM_RD     = mem_rd_s;
      MEM_WR     = mem_wr_s;
      MA_SEL     = ma_sel_s;
      IR_LD      = ir_ld_s;
      PC_INC     = pc_inc_s;
      PC_LD      = pc_ld_s;
      MD_INC     = md_inc_s;
      AC_OP      = ac_op_s;
      INSTR_DONE = instr_done_s;
      PC_TO_MD   = pc_to_md_s;
      AC_TO_MD   = ac_to_md_s;
    end else begin
      STATE      = IDLE;
      MEM_RD     = 1'b0;
      MEM_WR     = 1'b0;
      MA_SEL     = MA_PC;
      IR_LD      = 1'b0;
      PC_INC     = 1'b0;
      PC_LD      = 1'b0;
      MD_INC     = 1'b0;
      AC_OP      = 1'b0;
      INSTR_DONE = 1'b0;
      PC_TO_MD   = 1'b0;
      AC_TO_MD   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes the hand-computed
// per-cycle output vector for each cycle it drives; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, run, mem_done, skip;
  logic       aand, tad, isz, dca, jms, jmp, iot, opr, ind, ppind;
  logic [3:0] state;
  logic       mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, md_inc, ac_op, instr_done;
  logic       pc_to_md, ac_to_md;
  logic [1:0] ma_sel;

  // flag bits: {MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, MD_INC, AC_OP, INSTR_DONE, PC_TO_MD, AC_TO_MD}
  localparam logic [9:0] NONE  = 10'b00_0000_0000;
  localparam logic [9:0] MRD   = 10'b10_0000_0000;
  localparam logic [9:0] MWR   = 10'b01_0000_0000;
  localparam logic [9:0] IRLD  = 10'b00_1000_0000;
  localparam logic [9:0] PCINC = 10'b00_0100_0000;
  localparam logic [9:0] PCLD  = 10'b00_0010_0000;
  localparam logic [9:0] MDINC = 10'b00_0001_0000;
  localparam logic [9:0] ACOP  = 10'b00_0000_1000;
  localparam logic [9:0] DONE  = 10'b00_0000_0100;
  localparam logic [9:0] P2MD  = 10'b00_0000_0010;
  localparam logic [9:0] A2MD  = 10'b00_0000_0001;

  // opcode vectors {AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR}
  localparam logic [7:0] OP_TAD  = 8'b0100_0000;
  localparam logic [7:0] OP_ISZ  = 8'b0010_0000;
  localparam logic [7:0] OP_DCA  = 8'b0001_0000;
  localparam logic [7:0] OP_JMS  = 8'b0000_1000;
  localparam logic [7:0] OP_JMP  = 8'b0000_0100;
  localparam logic [7:0] OP_OPR  = 8'b0000_0001;
  localparam logic [7:0] OP_NONE = 8'b0000_0000;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  instr_sequencer dut (
    .CLK(clk), .RESET_N(reset_n), .RUN(run), .MEM_DONE(mem_done),
    .AAND(aand), .TAD(tad), .ISZ(isz), .DCA(dca), .JMS(jms), .JMP(jmp),
    .IOT(iot), .OPR(opr), .IND(ind), .PPIND(ppind), .SKIP(skip),
    .STATE(state), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MA_SEL(ma_sel),
    .IR_LD(ir_ld), .PC_INC(pc_inc), .PC_LD(pc_ld), .MD_INC(md_inc),
    .AC_OP(ac_op), .INSTR_DONE(instr_done), .PC_TO_MD(pc_to_md),
    .AC_TO_MD(ac_to_md)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic [7:0] ops, input logic i, input logic pp);
    {aand, tad, isz, dca, jms, jmp, iot, opr} = ops;
    ind   = i;
    ppind = pp;
  endtask

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic cyc(input logic rst, input logic r, input logic md, input logic sk,
                     input logic [3:0] st, input logic [1:0] ma, input logic [9:0] fl,
                     input string nm);
    reset_n  = rst;
    run      = r;
    mem_done = md;
    skip     = sk;
    exp_q.push_back({st, ma, fl});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT output vector on every falling edge that has an expectation queued.
  initial begin
    logic [15:0] e, a;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {state, ma_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, md_inc,
              ac_op, instr_done, pc_to_md, ac_to_md};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got state=%0d ma_sel=%0d flags=%b, expected state=%0d ma_sel=%0d flags=%b",
                   nm, a[15:12], a[11:10], a[9:0], e[15:12], e[11:10], e[9:0]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; run = 1'b1; mem_done = 1'b1; skip = 1'b0;
    set_op(OP_TAD, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset with RUN and MEM_DONE high, then release
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, NONE, "reset_0");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, NONE, "reset_1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, NONE, "idle_after_reset");

    // TAD direct, zero wait: 1,2,6
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "tad_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "tad_dec");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 2'd1, MRD | ACOP | DONE, "tad_exec");

    // TAD auto-index, two wait cycles on every access
    set_op(OP_TAD, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 2'd0, MRD, "ai_fetch_wait");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "ai_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "ai_dec");
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 2'd1, MRD, "ai_drd_wait");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 2'd1, MRD, "ai_drd");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 2'd0, MDINC, "ai_dinc");
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 2'd1, MWR, "ai_dwb_wait");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 2'd1, MWR, "ai_dwb");
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 2'd2, MRD, "ai_erd_wait");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 2'd2, MRD | ACOP | DONE, "ai_erd");

    // ISZ direct, SKIP=1 then SKIP=0 (indirect flag must be cleared again)
    set_op(OP_ISZ, 1'b0, 1'b0);
    for (int k = 1; k >= 0; k--) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "isz_fetch");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "isz_dec");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 2'd1, MRD, "isz_erd");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 2'd1, MDINC, "isz_einc");
      cyc(1'b1, 1'b1, 1'b1, k[0], 4'd8, 2'd1, (k == 1) ? (MWR | PCINC | DONE) : (MWR | DONE), "isz_ewr");
    end

    // JMS direct: 1,2,8,10,11
    set_op(OP_JMS, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "jms_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "jms_dec");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 2'd1, MWR | P2MD, "jms_ewr");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 2'd1, PCLD, "jms_jld");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 2'd1, PCINC | DONE, "jms_jinc");

    // DCA direct: 1,2,8
    set_op(OP_DCA, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "dca_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "dca_dec");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 2'd1, MWR | A2MD | ACOP | DONE, "dca_ewr");

    // JMP direct: 1,2,10
    set_op(OP_JMP, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "jmp_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "jmp_dec");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 2'd1, PCLD | DONE, "jmp_jld");

    // OPR, and no opcode at all (IND set but ignored): 1,2,9
    set_op(OP_OPR, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "opr_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "opr_dec");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 2'd1, ACOP | DONE, "opr_exe");
    set_op(OP_NONE, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "noop_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "noop_dec");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 2'd1, DONE, "noop_exe");

    // TAD indirect with RUN dropped during D_RD: completes, then stops
    set_op(OP_TAD, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "stop_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "stop_dec");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 2'd1, MRD, "stop_drd_wait");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 2'd1, MRD, "stop_drd");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 2'd2, MRD | ACOP | DONE, "stop_erd");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, NONE, "stop_idle");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, NONE, "restart_idle");

    // DCA with reset during an E_WR wait: request dropped at once
    set_op(OP_DCA, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, MRD | IRLD | PCINC, "rst_fetch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'd0, NONE, "rst_dec");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 2'd1, MWR | A2MD, "rst_ewr_wait");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, NONE, "rst_mid_ewr");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, NONE, "rst_idle_after");

    // Drain: every queued expectation must have been consumed by the monitor
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
